// File: rtl/pbit_pkg.sv
// Shared p-bit definitions: fixed-point word type, histogram FSM states, +/-1.0 constants.
package pbit_pkg;

    localparam int DEF_INT_SIZE   = 8;
    localparam int DEF_FLOAT_SIZE = 24;
    localparam int DEF_FXP_W      = DEF_INT_SIZE + DEF_FLOAT_SIZE;

    typedef logic signed [DEF_FXP_W-1:0] fxp_t;

    localparam fxp_t FXP_POS_ONE = fxp_t'(1) <<< DEF_FLOAT_SIZE;
    localparam fxp_t FXP_NEG_ONE = -FXP_POS_ONE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } hist_state_t;

endpackage

// File: rtl/pbit_state_decode.sv
// Combinational p-bit word to state-index decoder: bit k is 1 when word k is non-negative.
module pbit_state_decode
    import pbit_pkg::*;
#(
    parameter int NUM_PBITS = 3,
    parameter int WORD_W    = DEF_FXP_W
) (
    input  logic [NUM_PBITS*WORD_W-1:0] pbit_vals,
    output logic [NUM_PBITS-1:0]        state_idx
);

    // Only the sign matters; the signed compare reduces to the MSB in synthesis.
    always_comb begin
        state_idx = '0;
        for (int k = 0; k < NUM_PBITS; k++) begin
            state_idx[k] = ($signed(pbit_vals[k*WORD_W +: WORD_W]) >= 0);
        end
    end

endmodule

// File: rtl/pbit_state_histogram.sv
// Histogram of decoded p-bit states over a programmed sample window, with registered read port.
// Optional burn-in discard of the first strobes when PBIT_HISTOGRAM_BURNIN_EN is defined.
//
// state | meaning
// IDLE  | waiting for start after reset
// CLEAR | zeroing one bin per cycle, index 0 .. 2**NUM_PBITS-1
// RUN   | counting sample strobes until samples_taken hits the latched window
// DONE  | histogram frozen, done high until next start
module pbit_state_histogram
    import pbit_pkg::*;
#(
    parameter int NUM_PBITS    = 3,
    parameter int INT_SIZE     = DEF_INT_SIZE,
    parameter int FLOAT_SIZE   = DEF_FLOAT_SIZE,
    parameter int CNT_WIDTH    = 16,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      start,
    input  logic [SAMPLE_WIDTH-1:0]                   num_samples,
`ifdef PBIT_HISTOGRAM_BURNIN_EN
    input  logic [SAMPLE_WIDTH-1:0]                   burn_in,
`endif
    input  logic                                      sample_valid,
    input  logic [NUM_PBITS*(INT_SIZE+FLOAT_SIZE)-1:0] pbit_vals,
    input  logic [NUM_PBITS-1:0]                      rd_addr,
    output logic [CNT_WIDTH-1:0]                      rd_data,
    output logic                                      busy,
    output logic                                      done,
    output logic [SAMPLE_WIDTH-1:0]                   samples_taken
);

    localparam int                   NUM_BINS = 2**NUM_PBITS;
    localparam int                   WORD_W   = INT_SIZE + FLOAT_SIZE;
    localparam logic [NUM_PBITS-1:0] LAST_BIN = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    hist_state_t             state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] target_q;
    logic [NUM_PBITS-1:0]    clr_idx_q;
    logic [NUM_PBITS-1:0]    bin_idx;
    logic [CNT_WIDTH-1:0]    bins_q [NUM_BINS];
    logic                    start_ok, run_full, accept, burn_skip, count_en;

    pbit_state_decode #(
        .NUM_PBITS (NUM_PBITS),
        .WORD_W    (WORD_W)
    ) u_decode (
        .pbit_vals (pbit_vals),
        .state_idx (bin_idx)
    );

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign run_full = (samples_taken == target_q);
    assign accept   = (state_q == ST_RUN) && sample_valid && !run_full;
    assign count_en = accept && !burn_skip;

`ifdef PBIT_HISTOGRAM_BURNIN_EN
    logic [SAMPLE_WIDTH-1:0] burn_left_q;

    assign burn_skip = (burn_left_q != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            burn_left_q <= '0;
        end else if (start_ok) begin
            burn_left_q <= burn_in;
        end else if (accept && burn_skip) begin
            burn_left_q <= burn_left_q - 1'b1;
        end
    end
`else
    assign burn_skip = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_idx_q == LAST_BIN) state_d = ST_RUN;
            ST_RUN:   if (run_full) state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_CLEAR;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CLEAR) || (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            target_q      <= '0;
            samples_taken <= '0;
            clr_idx_q     <= '0;
        end else begin
            if (start_ok) begin
                target_q      <= num_samples;
                samples_taken <= '0;
                clr_idx_q     <= '0;
            end else begin
                if (state_q == ST_CLEAR) clr_idx_q <= clr_idx_q + 1'b1;
                if (count_en) samples_taken <= samples_taken + 1'b1;
            end
        end
    end

    // Saturating bins: a full counter holds rather than wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_BINS; i++) bins_q[i] <= '0;
        end else if (state_q == ST_CLEAR) begin
            bins_q[clr_idx_q] <= '0;
        end else if (count_en && (bins_q[bin_idx] != CNT_MAX)) begin
            bins_q[bin_idx] <= bins_q[bin_idx] + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data <= '0;
        end else begin
            rd_data <= bins_q[rd_addr];
        end
    end

endmodule
